// File: rtl/encoder_8_3_sequential.sv
// rtl/encoder_8_3_sequential.sv - registered 8-to-3 encoder with pending-request queue and valid/ack handshake
// Optional macro ROUND_ROBIN_EN: round-robin grant selection instead of fixed highest-index priority.
module encoder_8_3_sequential #(
    parameter int TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] d,
    input  logic       ack,
    output logic [2:0] i,
    output logic       valid,
    output logic       ovf,
    output logic       tout,
    output logic [3:0] cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam bit         TO_EN   = (TIMEOUT > 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [2:0] i_q, i_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    logic       tout_q, tout_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] set_v, clr_v;

    function automatic logic [3:0] popcount(input logic [7:0] p);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'd0, p[k]};
        end
        return n;
    endfunction

`ifdef ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;

    // Scan offsets downward so the smallest offset from ptr wins.
    function automatic logic [2:0] pick(input logic [7:0] p, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] sel;
        sel = start;
        for (int off = 7; off >= 0; off--) begin
            idx = start + 3'(off);
            if (p[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction
`else
    function automatic logic [2:0] pick(input logic [7:0] p);
        logic [2:0] sel;
        sel = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (p[k]) begin
                sel = 3'(k);
            end
        end
        return sel;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 8'h00;
            i_q     <= 3'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= 4'd0;
            tcnt_q  <= 8'd0;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            i_q     <= i_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        valid_d = valid_q;
        tout_d  = 1'b0;
        tcnt_d  = tcnt_q;
`ifdef ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif

        // Set is OR-ed after the clear so a same-cycle re-request keeps the bit.
        set_v  = en ? d : 8'h00;
        clr_v  = (valid_q && ack) ? (8'h01 << i_q) : 8'h00;
        pend_d = (pend_q & ~clr_v) | set_v;
        ovf_d  = |(set_v & pend_q & ~clr_v);
        cnt_d  = popcount(pend_d);

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (en && (pend_q != 8'h00)) begin
`ifdef ROUND_ROBIN_EN
                    i_d = pick(pend_q, ptr_q);
`else
                    i_d = pick(pend_q);
`endif
                    valid_d = 1'b1;
                    tcnt_d  = 8'd0;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
`ifdef ROUND_ROBIN_EN
                    ptr_d   = i_q + 3'd1;
`endif
                end else if (TO_EN && (tcnt_q == TO_LAST)) begin
                    valid_d = 1'b0;
                    tout_d  = 1'b1;
                    state_d = IDLE;
                end else if (TO_EN) begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign i     = i_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign tout  = tout_q;
    assign cnt   = cnt_q;

endmodule

// File: doc/encoder_8_3_sequential.md
Name: encoder_8_3_sequential

Overview:
Registered 8-to-3 encoder with request queuing. It is the return path for the 3-to-8 decoder: eight request lines are captured into a pending register, and the block presents one 3-bit index at a time on a valid/ack handshake. Served requests are cleared on acknowledge. It sits between request sources (interrupt or select lines) and a consumer that takes one encoded index per transaction.

Parameters:
TIMEOUT, 0, ack timeout in clk cycles while presenting; 0 disables timeout; legal range 0-255.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  capture/present enable.
d  input  8  request lines; d[k] high requests index k.
ack  input  1  consumer accepts the presented index.
i  output  3  encoded index of the granted request.
valid  output  1  i is valid and held stable until ack or timeout.
ovf  output  1  one-cycle pulse: a request arrived on a line already pending.
tout  output  1  one-cycle pulse: presentation abandoned on timeout.
cnt  output  4  registered count of set pending bits, 0-8.

Behaviour:
- Reset: rst_n low asynchronously clears all state. pend=8'h00, state=IDLE, i=3'd0, valid=0, ovf=0, tout=0, cnt=4'd0, timeout counter=0.
- Single clock domain. All outputs are registered.
- Capture, every edge: set = en ? d : 8'h00; clr = one-hot(i) when (valid && ack), else 8'h00; pend <= (pend & ~clr) | set.
- Simultaneous set and clear on the same bit: set wins, so the bit stays pending.
- ovf <= |(set & pend & ~clr). It pulses for one cycle and does not block capture.
- cnt <= popcount of the next pend value.
- State IDLE:
  - If en && pend != 0: i <= selected index, valid <= 1, timeout counter <= 0, go to PRESENT.
  - Otherwise valid stays 0.
- Selection (default): fixed priority, highest set index wins. pend=8'b0010_0110 gives i=5.
- Selection uses the registered pend only. A request on d is not presented in the same cycle.
- State PRESENT:
  - i and valid are held stable regardless of en or d. A presented index is never withdrawn except on timeout.
  - On ack: clear pend[i] (subject to set-wins), valid <= 0, go to IDLE.
  - There is one dead cycle between grants, so maximum throughput is one grant per 2 cycles.
  - When TIMEOUT>0, the counter increments each PRESENT cycle without ack.
  - When the counter reaches TIMEOUT-1 without ack: valid <= 0, pend[i] is kept, tout pulses 1 cycle, go to IDLE.
  - ack on the cycle the timeout would fire: ack wins and tout stays 0.
- ack while valid=0 is ignored.
- Latency: d[k] high at edge N with en=1 gives pend[k] set after edge N, and valid=1 with i=k after edge N+1, when IDLE and k is the highest pending bit.
- en=0: no capture and no new presentation. pend is retained. An in-progress PRESENT still completes on ack or timeout.
- Reset mid-transaction: valid drops immediately (asynchronously) and all pending requests are lost.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined:
  - Selection becomes round-robin using a 3-bit pointer ptr, reset value 0.
  - The search runs ptr, ptr+1, ... wrapping mod 8. The first pending bit found is granted.
  - On ack of index k, ptr <= (k+1) mod 8. Timeout does not move ptr.
- Undefined: fixed highest-index priority as above, and no pointer register exists.

Test Plan:
- Reset and single request: rst_n low, then high; d=8'h08 for 1 cycle with en=1 → valid=1 and i=3 two edges later; ack=1 for 1 cycle → valid=0, pend=0, cnt=0.
- Fixed priority: d=8'hA5 for 1 cycle, then ack each presentation → i sequence 7,5,2,0; cnt steps 4,3,2,1,0; one idle cycle between grants.
- Overflow and set-wins: pend[4] set; drive d=8'h10 again → ovf pulses 1 cycle. Assert d[4] on the same edge as ack of i=4 → pend[4] remains 1 and i=4 is re-presented.
- Enable gating: en=0, d=8'hFF → pend stays 0, valid=0. Raise en=0 during PRESENT with i=6 → valid held until ack.
- Timeout with TIMEOUT=4: present i=2 with no ack → valid falls after 4 PRESENT cycles, tout pulses once, pend[2] still 1, i=2 re-presented. Ack on the 4th cycle → tout=0 and pend[2] cleared.
- ROUND_ROBIN_EN defined: keep d=8'h81 asserted continuously and ack every grant → i alternates 0,7,0,7. Without the macro → i stays 7 every grant.
